// File: rtl/workbench_pkg.sv
// Shared definitions for the jerk-limited velocity profiler.
//   A_MAX_LIMIT : largest supported acceleration limit
//   VEL_W       : velocity width (unsigned)
//   ACC_W       : acceleration width (signed two's complement)
//   tri_sum(c)  : c*(c+1)/2, the velocity covered while ramping |a| from c down to 0
package workbench_pkg;

    localparam int A_MAX_LIMIT = 255;
    localparam int VEL_W       = 16;
    localparam int ACC_W       = 16;

    // 9-bit input so that c = A_MAX+1 (= 256) can be formed without wrapping.
    function automatic logic [VEL_W:0] tri_sum(input logic [8:0] c);
        logic [17:0] p;
        p = {9'd0, c} * ({9'd0, c} + 18'd1);
        return (VEL_W+1)'(p >> 1);
    endfunction

endpackage

// File: rtl/scurve_step.sv
// One combinational S-curve profile update.
//   vel      in  : current velocity (unsigned)
//   acc      in  : current acceleration (signed)
//   target   in  : registered target velocity (unsigned)
//   vel_next out : velocity after this tick, saturated to 0..2^VEL_W-1
//   acc_next out : acceleration after this tick, |acc_next - acc| <= 1
module scurve_step
    import workbench_pkg::*;
#(
    parameter int A_MAX = 16
) (
    input  logic        [VEL_W-1:0] vel,
    input  logic signed [ACC_W-1:0] acc,
    input  logic        [VEL_W-1:0] target,
    output logic        [VEL_W-1:0] vel_next,
    output logic signed [ACC_W-1:0] acc_next
);

    localparam logic signed [ACC_W-1:0] A_LIM = ACC_W'(A_MAX);

    logic signed [VEL_W:0]   err;
    logic        [VEL_W:0]   err_mag;
    logic signed [ACC_W-1:0] ar;
    logic signed [ACC_W-1:0] c;
    logic        [8:0]       c_hold;
    logic        [8:0]       c_up;
    logic        [8:0]       c_dn;
    logic        [VEL_W+1:0] vel_sum;

    always_comb begin
        err      = $signed({1'b0, target}) - $signed({1'b0, vel});
        err_mag  = err[VEL_W] ? $unsigned(-err) : $unsigned(err);
        // Acceleration expressed relative to the direction of the error:
        // positive means "currently moving toward the target".
        ar       = err[VEL_W] ? -acc : acc;
        c_hold   = ar[8:0];
        c_up     = c_hold + 9'd1;
        c_dn     = c_hold - 9'd1;
        c        = '0;
        acc_next = '0;

        if (err == '0) begin
            if (acc > 0)
                acc_next = acc - 16'sd1;
            else if (acc < 0)
                acc_next = acc + 16'sd1;
            else
                acc_next = '0;
        end else begin
            if (ar < 0) begin
                c = ar + 16'sd1;
            end else begin
                // Candidates are tried smallest first so the largest one that
                // still allows braking to zero within |err| wins.
                c = ar - 16'sd1;
                if (ar >= 16'sd1 && tri_sum(c_dn) <= err_mag)
                    c = ar - 16'sd1;
                if (ar <= A_LIM && tri_sum(c_hold) <= err_mag)
                    c = ar;
                if (ar < A_LIM && tri_sum(c_up) <= err_mag)
                    c = ar + 16'sd1;
            end
            acc_next = err[VEL_W] ? -c : c;
        end

        vel_sum = {2'b00, vel} + {{(VEL_W+2-ACC_W){acc_next[ACC_W-1]}}, acc_next};
        if (vel_sum[VEL_W+1])
            vel_next = '0;
        else if (vel_sum[VEL_W])
            vel_next = '1;
        else
            vel_next = vel_sum[VEL_W-1:0];
    end

endmodule

// File: rtl/velocity_workbench.sv
// Jerk-limited (S-curve) velocity profiler between the command register and
// the step generator. o_value ramps toward i_value with |a| <= A_MAX and the
// acceleration changing by at most one LSB per profile tick.
//   i_clk      in  : system clock
//   i_reset    in  : synchronous active-high reset
//   i_value    in  : target velocity (unsigned)
//   o_value    out : current velocity (unsigned, registered)
//   o_accel    out : current acceleration (signed)
//   o_settled  out : velocity equals registered target and acceleration is 0
module velocity_workbench
    import workbench_pkg::*;
#(
    parameter int A_MAX    = 16,
    parameter int TICK_DIV = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic        [VEL_W-1:0] i_value,
    output logic        [VEL_W-1:0] o_value,
    output logic signed [ACC_W-1:0] o_accel,
    output logic                    o_settled
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic        [VEL_W-1:0] target_q;
    logic        [VEL_W-1:0] vel;
    logic signed [ACC_W-1:0] acc;
    logic        [CNT_W-1:0] tick_cnt;
    logic                    tick;
    logic        [VEL_W-1:0] vel_nx;
    logic signed [ACC_W-1:0] acc_nx;

    assign tick = (tick_cnt == CNT_LAST);

    scurve_step #(
        .A_MAX (A_MAX)
    ) u_step (
        .vel      (vel),
        .acc      (acc),
        .target   (target_q),
        .vel_next (vel_nx),
        .acc_next (acc_nx)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            target_q <= '0;
            vel      <= '0;
            acc      <= '0;
            tick_cnt <= '0;
        end else begin
            target_q <= i_value;
            if (tick) begin
                tick_cnt <= '0;
                vel      <= vel_nx;
                acc      <= acc_nx;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    assign o_value   = vel;
    assign o_accel   = acc;
    assign o_settled = (vel == target_q) && (acc == '0);

endmodule

// File: tb/tb_velocity_workbench.sv
// Bench for velocity_workbench: two instances (TICK_DIV=1 and TICK_DIV=4)
// share reset and target. Every cycle the stimulus advances an integer
// reference model and queues the expected outputs; a negedge monitor pops
// and compares. Directed sequences from the profile examples are also
// checked against constant tables.
module tb_velocity_workbench;

    localparam int A_MAX = 16;

    typedef struct {
        int v;
        int a;
        int s;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic        [15:0] val;
    logic        [15:0] out_v [2];
    logic signed [15:0] out_a [2];
    logic               out_s [2];

    int checks = 0;
    int errors = 0;

    exp_t q0[$];
    exp_t q1[$];

    int m_tgt [2];
    int m_vel [2];
    int m_acc [2];
    int m_cnt [2];
    int div   [2] = '{1, 4};

    int exp1 [18] = '{1, 3, 6, 10, 15, 21, 28, 36, 45, 53, 60, 67, 73, 78, 82, 85, 87, 88};
    int exp2 [9]  = '{87, 85, 82, 78, 74, 71, 69, 67, 66};

    always #5 clk = ~clk;

    velocity_workbench #(.A_MAX(A_MAX), .TICK_DIV(1)) dut0 (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_value   (val),
        .o_value   (out_v[0]),
        .o_accel   (out_a[0]),
        .o_settled (out_s[0])
    );

    velocity_workbench #(.A_MAX(A_MAX), .TICK_DIV(4)) dut1 (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_value   (val),
        .o_value   (out_v[1]),
        .o_accel   (out_a[1]),
        .o_settled (out_s[1])
    );

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: what one rising edge does to profiler d.
    function automatic void model_edge(input int d, input bit r, input int v);
        int e, s, mag, ar, c, nv;
        if (r) begin
            m_tgt[d] = 0;
            m_vel[d] = 0;
            m_acc[d] = 0;
            m_cnt[d] = 0;
            return;
        end
        if (m_cnt[d] == div[d] - 1) begin
            e = m_tgt[d] - m_vel[d];
            if (e == 0) begin
                if (m_acc[d] > 0) m_acc[d] = m_acc[d] - 1;
                else if (m_acc[d] < 0) m_acc[d] = m_acc[d] + 1;
            end else begin
                s   = (e > 0) ? 1 : -1;
                mag = e * s;
                ar  = s * m_acc[d];
                if (ar < 0) begin
                    c = ar + 1;
                end else begin
                    c = ar - 1;
                    for (int k = ar - 1; k <= ar + 1; k++)
                        if (k >= 0 && k <= A_MAX && k * (k + 1) / 2 <= mag)
                            c = k;
                end
                m_acc[d] = s * c;
            end
            nv = m_vel[d] + m_acc[d];
            if (nv < 0) nv = 0;
            if (nv > 65535) nv = 65535;
            m_vel[d] = nv;
            m_cnt[d] = 0;
        end else begin
            m_cnt[d] = m_cnt[d] + 1;
        end
        m_tgt[d] = v;
    endfunction

    function automatic exp_t model_out(input int d);
        exp_t x;
        x.v = m_vel[d];
        x.a = m_acc[d];
        x.s = (m_vel[d] == m_tgt[d] && m_acc[d] == 0) ? 1 : 0;
        return x;
    endfunction

    // Drive one cycle of inputs; returns 1 time unit after the edge.
    task automatic step(input bit r, input int v);
        rst = r;
        val = 16'(v);
        model_edge(0, r, v);
        model_edge(1, r, v);
        @(posedge clk);
        #1;
        q0.push_back(model_out(0));
        q1.push_back(model_out(1));
    endtask

    task automatic wait_settle(input int v, input int limit);
        int n;
        n = 0;
        while (!out_s[0] && n < limit) begin
            step(1'b0, v);
            n++;
        end
        if (n >= limit) begin
            checks++;
            errors++;
            $display("FAIL settle_timeout target=%0d actual_vel=%0d required_settled=1", v, out_v[0]);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("sb0_vel",     int'(out_v[0]), e.v);
                check("sb0_acc",     int'(out_a[0]), e.a);
                check("sb0_settled", int'(out_s[0]), e.s);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("sb1_vel",     int'(out_v[1]), e.v);
                check("sb1_acc",     int'(out_a[1]), e.a);
                check("sb1_settled", int'(out_s[1]), e.s);
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int v;
        int len;
        rst = 1'b1;
        val = '0;
        for (int d = 0; d < 2; d++) model_edge(d, 1'b1, 0);

        // Reset state
        step(1'b1, 0);
        step(1'b1, 0);
        check("rst_vel",     int'(out_v[0]), 0);
        check("rst_acc",     int'(out_a[0]), 0);
        check("rst_settled", int'(out_s[0]), 1);
        check("rst_vel_b",   int'(out_v[1]), 0);

        // 0 -> 88
        step(1'b0, 88);
        for (int i = 0; i < 18; i++) begin
            step(1'b0, 88);
            check("t1_vel", int'(out_v[0]), exp1[i]);
        end
        step(1'b0, 88);
        step(1'b0, 88);
        check("t1_hold_vel", int'(out_v[0]), 88);
        check("t1_acc",      int'(out_a[0]), 0);
        check("t1_settled",  int'(out_s[0]), 1);

        // 88 -> 66
        step(1'b0, 66);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 66);
            check("t2_vel", int'(out_v[0]), exp2[i]);
        end
        step(1'b0, 66);
        check("t2_acc", int'(out_a[0]), 0);
        check("t2_vel_hold", int'(out_v[0]), 66);

        // 0 -> 1000: acceleration saturates at A_MAX
        step(1'b1, 0);
        step(1'b0, 1000);
        for (int i = 0; i < 16; i++) step(1'b0, 1000);
        check("t3_acc_max", int'(out_a[0]), 16);
        check("t3_vel_136", int'(out_v[0]), 136);
        step(1'b0, 1000);
        check("t3_vel_152", int'(out_v[0]), 152);
        check("t3_acc_hold", int'(out_a[0]), 16);
        wait_settle(1000, 400);
        check("t3_final_vel", int'(out_v[0]), 1000);
        check("t3_final_acc", int'(out_a[0]), 0);

        // Target change mid-ramp
        step(1'b1, 0);
        for (int i = 0; i < 5; i++) step(1'b0, 88);
        step(1'b0, 66);
        wait_settle(66, 200);
        check("t4_final_vel", int'(out_v[0]), 66);
        check("t4_final_acc", int'(out_a[0]), 0);

        // Reset mid-ramp, then restart
        step(1'b1, 0);
        for (int i = 0; i < 6; i++) step(1'b0, 88);
        step(1'b1, 88);
        check("t5_rst_vel", int'(out_v[0]), 0);
        check("t5_rst_acc", int'(out_a[0]), 0);
        step(1'b0, 88);
        step(1'b0, 88);
        check("t5_vel_1", int'(out_v[0]), 1);
        step(1'b0, 88);
        check("t5_vel_3", int'(out_v[0]), 3);
        step(1'b0, 88);
        check("t5_vel_6", int'(out_v[0]), 6);

        // TICK_DIV=4 instance, target 3
        step(1'b1, 0);
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 3);
            if (k == 3)  check("t6_k3_vel",  int'(out_v[1]), 0);
            if (k == 4)  check("t6_k4_vel",  int'(out_v[1]), 1);
            if (k == 7)  check("t6_k7_vel",  int'(out_v[1]), 1);
            if (k == 8)  check("t6_k8_vel",  int'(out_v[1]), 2);
            if (k == 12) check("t6_k12_vel", int'(out_v[1]), 3);
            if (k == 16) begin
                check("t6_settled", int'(out_s[1]), 1);
                check("t6_acc",     int'(out_a[1]), 0);
            end
        end

        // Randomised targets, hold lengths and occasional resets
        for (int seg = 0; seg < 16; seg++) begin
            v = $urandom_range(0, 3000);
            if ($urandom_range(0, 9) == 0) v = $urandom_range(62000, 65535);
            if ($urandom_range(0, 7) == 0) step(1'b1, v);
            len = $urandom_range(20, 350);
            for (int i = 0; i < len; i++) step(1'b0, v);
        end

        step(1'b0, int'(val));
        step(1'b0, int'(val));
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
